// File: rtl/ov7670_stream_pkg.sv
// Shared types and helpers for the OV7670 stream emulator.
// Frame states, pattern codes and line geometry.
package ov7670_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_e;

  localparam logic [1:0] PAT_COUNT = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_CONST = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  function automatic int line_len(
    input int cols,
    input int bpp,
    input int hblank
  );
    return cols * bpp + hblank;
  endfunction

endpackage

// File: rtl/ov7670_stream_gen_pattern.sv
// Registered test-pattern mux for the OV7670 emulator.
// Loads on tick; outputs zero outside the active window.
module ov7670_pattern_gen
  import ov7670_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       valid,
  input  logic [1:0] pattern,
  input  logic [7:0] b_lo,
  input  logic [3:0] col_lo,
  input  logic [3:0] r_lo,
  input  logic [7:0] cnst,
  output logic [7:0] data
);

  logic [7:0] data_d;
  logic [7:0] data_q;
  logic       chk;

  always_comb begin
    chk    = |((r_lo ^ col_lo) & 4'b1000);
    data_d = data_q;
    if (en) begin
      data_d = 8'h00;
      if (valid) begin
        unique case (pattern)
          PAT_COUNT: data_d = b_lo;
          PAT_BARS:  data_d = {col_lo[2:0], 5'b0};
          PAT_CONST: data_d = cnst;
          PAT_CHECK: data_d = chk ? 8'hFF : 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= 8'h00;
    else     data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 parallel-bus transmitter: PCLK/VSYNC/HREF/D with test patterns.
// Everything except PCLK advances on the PCLK falling edge (tick).
module ov7670_stream_gen
  import ov7670_stream_pkg::*;
#(
  parameter int ACTIVE_COLS     = 32,
  parameter int ACTIVE_ROWS     = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int H_BLANK         = 144,
  parameter int VS_LINES        = 3,
  parameter int VBP_LINES       = 17,
  parameter int VFP_LINES       = 10
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic [1:0] i_Pattern,
  input  logic [7:0] i_Const,
  output logic       o_PCLK,
  output logic       o_VSYNC,
  output logic       o_HREF,
  output logic [7:0] o_D,
  output logic       o_Frame_Done,
  output logic       o_Busy
);

  localparam int ACT_BYTES = ACTIVE_COLS * BYTES_PER_PIXEL;
  localparam int LINE_LEN  = line_len(ACTIVE_COLS, BYTES_PER_PIXEL, H_BLANK);
  localparam int MAX_A     = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
  localparam int MAX_B     = (ACTIVE_ROWS > VFP_LINES) ? ACTIVE_ROWS : VFP_LINES;
  localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LW        = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int NW        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  localparam logic [LW-1:0] LINE_LAST = LW'(LINE_LEN - 1);
  localparam logic [LW-1:0] HREF_END  = LW'(ACT_BYTES);
  localparam logic [LW-1:0] BPP_W     = LW'(BYTES_PER_PIXEL);

  state_e          state_d, state_q;
  logic [LW-1:0]   line_d, line_q;
  logic [NW-1:0]   lines_d, lines_q;
  logic [NW-1:0]   phase_last;
  logic [1:0]      pat_d, pat_q;
  logic [7:0]      cnst_d, cnst_q;
  logic            pclk_d, pclk_q;
  logic            vsync_d, vsync_q;
  logic            href_d, href_q;
  logic            done_d, done_q;
  logic            busy_d, busy_q;
  logic            tick, line_end, phase_end;
  logic [LW-1:0]   col_d;

  assign tick = pclk_q;

  always_comb begin
    unique case (state_q)
      VSYNC:   phase_last = NW'(VS_LINES - 1);
      VBACK:   phase_last = NW'(VBP_LINES - 1);
      ACTIVE:  phase_last = NW'(ACTIVE_ROWS - 1);
      VFRONT:  phase_last = NW'(VFP_LINES - 1);
      default: phase_last = '0;
    endcase
  end

  always_comb begin
    pclk_d    = ~pclk_q;
    state_d   = state_q;
    line_d    = line_q;
    lines_d   = lines_q;
    pat_d     = pat_q;
    cnst_d    = cnst_q;
    done_d    = 1'b0;
    line_end  = (line_q == LINE_LAST);
    phase_end = line_end && (lines_q == phase_last);
    if (tick) begin
      if (state_q == IDLE) begin
        if (i_Enable) begin
          state_d = VSYNC;
          pat_d   = i_Pattern;
          cnst_d  = i_Const;
        end
      end else begin
        line_d = line_end ? '0 : line_q + 1'b1;
        if (line_end) lines_d = phase_end ? '0 : lines_q + 1'b1;
        if (phase_end) begin
          unique case (state_q)
            VSYNC:  state_d = VBACK;
            VBACK:  state_d = ACTIVE;
            ACTIVE: state_d = VFRONT;
            default: begin
              done_d = 1'b1;
              // Back-to-back frames relatch pattern and constant here.
              if (i_Enable) begin
                state_d = VSYNC;
                pat_d   = i_Pattern;
                cnst_d  = i_Const;
              end else begin
                state_d = IDLE;
              end
            end
          endcase
        end
      end
    end
    vsync_d = (state_d == VSYNC);
    href_d  = (state_d == ACTIVE) && (line_d < HREF_END);
    busy_d  = (state_d != IDLE);
    col_d   = line_d / BPP_W;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pclk_q  <= 1'b0;
      state_q <= IDLE;
      line_q  <= '0;
      lines_q <= '0;
      pat_q   <= 2'd0;
      cnst_q  <= 8'h00;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pclk_q  <= pclk_d;
      state_q <= state_d;
      line_q  <= line_d;
      lines_q <= lines_d;
      pat_q   <= pat_d;
      cnst_q  <= cnst_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Fed from next-state values so the registered byte lines up with HREF.
  ov7670_pattern_gen u_pat (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .en      (tick),
    .valid   (href_d),
    .pattern (pat_d),
    .b_lo    (8'(line_d)),
    .col_lo  (4'(col_d)),
    .r_lo    (4'(lines_d)),
    .cnst    (cnst_d),
    .data    (o_D)
  );

  assign o_PCLK       = pclk_q;
  assign o_VSYNC      = vsync_q;
  assign o_HREF       = href_q;
  assign o_Frame_Done = done_q;
  assign o_Busy       = busy_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench for ov7670_stream_gen with a small frame geometry.
// Stimulus queues expected bytes; a monitor checks bytes and timing.
module tb_ov7670_stream_gen;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Enable = 1'b0;
  logic [1:0] i_Pattern = 2'd0;
  logic [7:0] i_Const = 8'h00;
  logic       o_PCLK, o_VSYNC, o_HREF, o_Frame_Done, o_Busy;
  logic [7:0] o_D;

  always #5 i_Clk = ~i_Clk;

  ov7670_stream_gen #(
    .ACTIVE_COLS(4), .ACTIVE_ROWS(2), .BYTES_PER_PIXEL(2), .H_BLANK(4),
    .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable),
    .i_Pattern(i_Pattern), .i_Const(i_Const),
    .o_PCLK(o_PCLK), .o_VSYNC(o_VSYNC), .o_HREF(o_HREF), .o_D(o_D),
    .o_Frame_Done(o_Frame_Done), .o_Busy(o_Busy)
  );

  int cmps = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  int vs_rises = 0, fd_cnt = 0, href_lines = 0;
  int clk_since = 0, tick_since = 0, vs_len = 0, hr_len = 0, line_idx = 0;
  logic prev_vs = 0, prev_hr = 0, have_prev = 0;
  logic [7:0] prev_d = 0;

  task automatic check(input string nm, input int act, input int exp);
    cmps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge i_Clk) begin
    if (i_Rst) begin
      have_prev = 0; prev_vs = 0; prev_hr = 0;
      vs_len = 0; hr_len = 0; line_idx = 0;
      clk_since = 0; tick_since = 0;
    end else begin
      clk_since++;
      if (have_prev && o_D !== prev_d) check("d_change_edge", o_PCLK, 0);
      prev_d = o_D; have_prev = 1;
      if (o_Frame_Done) begin
        fd_cnt++;
        check("done_time_clk", clk_since, 120);
        check("lines_in_frame", line_idx, 2);
      end
      if (o_PCLK == 1'b0) begin
        tick_since++;
        check("vs_href_overlap", int'(o_VSYNC & o_HREF), 0);
        if (o_VSYNC && !prev_vs) begin
          vs_rises++;
          if (o_Frame_Done) check("frame_gap_ticks", tick_since, 60);
          tick_since = 0; clk_since = 0; line_idx = 0; vs_len = 0;
        end
        if (o_VSYNC) vs_len++;
        else if (prev_vs) check("vsync_len", vs_len, 12);
        if (o_HREF) begin
          if (!prev_hr) check("href_start", tick_since, 24 + 12 * line_idx);
          hr_len++;
          if (exp_q.size() == 0) begin
            cmps++; fails++;
            $display("FAIL data_unexpected: got 0x%0h expected none", o_D);
          end else begin
            check("data", int'(o_D), int'(exp_q.pop_front()));
          end
        end else begin
          if (prev_hr) begin
            check("href_len", hr_len, 8);
            hr_len = 0; line_idx++; href_lines++;
          end
          check("d_blank", int'(o_D), 0);
        end
        prev_vs = o_VSYNC; prev_hr = o_HREF;
      end
    end
  end

  function automatic int get_cnt(input int sel);
    case (sel)
      0: return vs_rises;
      1: return fd_cnt;
      default: return href_lines;
    endcase
  endfunction

  task automatic wait_evt(input string nm, input int sel, input int target);
    int n = 0;
    while (get_cnt(sel) < target && n < 400) begin
      @(negedge i_Clk); n++;
    end
    if (get_cnt(sel) < target) begin
      cmps++; fails++;
      $display("FAIL %s_timeout: got %0d expected %0d", nm, get_cnt(sel), target);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int pat, input int b, input logic [7:0] c);
    logic [7:0] bars [8];
    bars = '{8'h00, 8'h00, 8'h20, 8'h20, 8'h40, 8'h40, 8'h60, 8'h60};
    case (pat)
      0: return 8'(b);
      1: return bars[b];
      2: return c;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [7:0] c);
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 8; b++) exp_q.push_back(exp_byte(pat, b, c));
  endtask

  task automatic check_outs_zero(input string nm);
    check({nm, "_pclk"}, int'(o_PCLK), 0);
    check({nm, "_vsync"}, int'(o_VSYNC), 0);
    check({nm, "_href"}, int'(o_HREF), 0);
    check({nm, "_d"}, int'(o_D), 0);
    check({nm, "_done"}, int'(o_Frame_Done), 0);
    check({nm, "_busy"}, int'(o_Busy), 0);
  endtask

  task automatic run_frame(input int pat, input logic [7:0] c);
    int v = vs_rises, f = fd_cnt;
    push_frame(pat, c);
    i_Pattern = 2'(pat); i_Const = c; i_Enable = 1'b1;
    wait_evt("vs_rise", 0, v + 1);
    check("busy_in_frame", int'(o_Busy), 1);
    i_Enable = 1'b0;
    wait_evt("frame_done", 1, f + 1);
    check("busy_after", int'(o_Busy), 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, f, h;
    repeat (4) @(negedge i_Clk);
    check_outs_zero("reset");
    i_Rst = 1'b0;
    repeat (4) @(negedge i_Clk);

    run_frame(0, 8'h00);
    run_frame(1, 8'h00);
    run_frame(3, 8'h00);

    // Constant and pattern changes mid-frame, back-to-back frames
    v = vs_rises; f = fd_cnt;
    push_frame(2, 8'hA5);
    push_frame(2, 8'h3C);
    i_Pattern = 2'd2; i_Const = 8'hA5; i_Enable = 1'b1;
    wait_evt("vs_rise_b1", 0, v + 1);
    repeat (30) @(negedge i_Clk);
    i_Const = 8'h3C;
    wait_evt("vs_rise_b2", 0, v + 2);
    i_Pattern = 2'd3;
    repeat (30) @(negedge i_Clk);
    i_Enable = 1'b0;
    wait_evt("frame_done_b2", 1, f + 2);
    check("b2b_rises", vs_rises - v, 2);
    check("b2b_busy_after", int'(o_Busy), 0);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Enable dropped during ACTIVE
    v = vs_rises; f = fd_cnt; h = href_lines;
    push_frame(1, 8'h00);
    i_Pattern = 2'd1; i_Enable = 1'b1;
    wait_evt("href_line", 2, h + 1);
    i_Enable = 1'b0;
    wait_evt("frame_done_drop", 1, f + 1);
    check("drop_busy", int'(o_Busy), 0);
    repeat (200) @(negedge i_Clk);
    check("drop_no_vsync", vs_rises - v, 1);
    check("drop_idle_busy", int'(o_Busy), 0);
    check("drop_queue_empty", exp_q.size(), 0);

    // Reset in the middle of an active line
    v = vs_rises; f = fd_cnt; h = href_lines;
    push_frame(0, 8'h00);
    i_Pattern = 2'd0; i_Enable = 1'b1;
    wait_evt("href_line_r", 2, h + 1);
    repeat (9) @(negedge i_Clk);
    check("pre_rst_href", int'(o_HREF), 1);
    @(posedge i_Clk);
    #1 i_Rst = 1'b1;
    #1 check_outs_zero("midrst");
    exp_q.delete();
    push_frame(0, 8'h00);
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    v = vs_rises; f = fd_cnt;
    wait_evt("vs_rise_after_rst", 0, v + 1);
    i_Enable = 1'b0;
    wait_evt("frame_done_after_rst", 1, f + 1);
    check("rst_queue_empty", exp_q.size(), 0);

    repeat (20) @(negedge i_Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
